// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_pkg
//  Description : Shared constants for the unified-memory port arbiter:
//                FSM state encoding, requester IDs, latency counter width
//                and the MEM_LAT legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

  // Latency counter width; MEM_LAT is at most 7.
  localparam int LAT_CNT_W = 3;

  // Arbiter FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Requester IDs, also used as the Owner / LastOwner encoding
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  typedef logic [0:0] arb_state_t;

  // Legal memory latencies must fit the down-counter and be non-zero.
  function automatic bit mem_lat_legal(input int lat);
    return (lat >= 1) && (lat <= 7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Combinational winner selection between fetch and data
//                requesters. With ARB_RR_EN defined, ties alternate using a
//                1-bit LastOwner register; otherwise data always beats fetch.
//  Macro       : ARB_RR_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
  import cpu_mem_pkg::*;
(
  input  logic Clock,
  input  logic ResetN,
  input  logic IfReq,
  input  logic DmReq,
  input  logic Grant,    // a grant is issued this cycle to PickDm's choice
  output logic PickDm    // 1 = data port wins, 0 = fetch port wins
);

`ifdef ARB_RR_EN
  logic last_owner_q;
  logic last_owner_d;

  // Tie goes to whoever did not win last; remember each granted winner.
  always_comb begin
    PickDm       = DmReq & (~IfReq | (last_owner_q == REQ_IF));
    last_owner_d = last_owner_q;
    if (Grant) begin
      last_owner_d = PickDm ? REQ_DM : REQ_IF;
    end
  end

  // LastOwner starts at IF so data takes the first tie after reset.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      last_owner_q <= REQ_IF;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Fixed priority needs no state, so the clock, reset and grant are idle.
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{Clock, ResetN, Grant};

  // Data wins whenever it asks; fetch only wins when data is quiet.
  always_comb begin
    PickDm = DmReq;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port unified memory between the fetch
//                and load/store paths. Grants one access at a time, counts
//                out MEM_LAT cycles, registers read data back to the owner
//                and raises Stall while any access is outstanding.
//  Macro       : ARB_RR_EN (round-robin tie-break; fixed DM>IF otherwise)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              Clock,
  input  logic              ResetN,
  // fetch port
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic              IfGnt,
  output logic              IfValid,
  output logic [DATA_W-1:0] IfRData,
  // data port
  input  logic              DmReq,
  input  logic              DmWe,
  input  logic [ADDR_W-1:0] DmAddr,
  input  logic [DATA_W-1:0] DmWData,
  output logic              DmGnt,
  output logic              DmValid,
  output logic [DATA_W-1:0] DmRData,
  // memory macro
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  // datapath hold
  output logic              Stall
);

  // Reject out-of-range latencies at elaboration.
  if (!mem_lat_legal(MEM_LAT)) begin : g_lat_illegal
    $error("mem_port_arbiter: MEM_LAT must be in 1..7");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

  arb_state_t           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q,   cnt_d;
  logic                 owner_q, owner_d;
  logic                 store_q, store_d;
  logic                 if_valid_q, if_valid_d;
  logic                 dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]    dm_rdata_q, dm_rdata_d;

  logic grant;
  logic pick_dm;
  logic if_gnt;
  logic dm_gnt;

  // Grants are gated by ResetN: a grant in a reset cycle would be dropped
  // by the state reset, so the requester must not see it as accepted.
  assign grant  = (state_q == ST_IDLE) & ResetN & (IfReq | DmReq);
  assign if_gnt = grant & ~pick_dm;
  assign dm_gnt = grant &  pick_dm;

  arb_pick u_arb_pick (
    .Clock  (Clock),
    .ResetN (ResetN),
    .IfReq  (IfReq),
    .DmReq  (DmReq),
    .Grant  (grant),
    .PickDm (pick_dm)
  );

  // Next-state: accept a winner in IDLE, count latency down in BUSY and
  // capture read data into the owner's register on the last BUSY cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    store_d    = store_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_BUSY;
          cnt_d   = LAT_LOAD;
          owner_d = dm_gnt ? REQ_DM : REQ_IF;
          store_d = dm_gnt & DmWe;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          if (owner_q == REQ_DM) begin
            dm_valid_d = 1'b1;
            // A store completes without touching the load data register.
            if (!store_q) begin
              dm_rdata_d = MemRData;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = MemRData;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and return-path registers; reset abandons any outstanding access.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= REQ_IF;
      store_q    <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      store_q    <= store_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Memory strobe and payload come straight from the winner; all zero
  // whenever no grant is issued.
  always_comb begin
    MemEn    = grant;
    MemWe    = dm_gnt & DmWe;
    MemAddr  = '0;
    MemWData = '0;
    if (dm_gnt) begin
      MemAddr  = DmAddr;
      MemWData = DmWData;
    end else if (if_gnt) begin
      MemAddr  = IfAddr;
    end
  end

  assign IfGnt   = if_gnt;
  assign DmGnt   = dm_gnt;
  assign IfValid = if_valid_q;
  assign DmValid = dm_valid_q;
  assign IfRData = if_rdata_q;
  assign DmRData = dm_rdata_q;

  // Hold the datapath while busy or while any request is left waiting.
  assign Stall = (state_q == ST_BUSY) | (IfReq & ~if_gnt) | (DmReq & ~dm_gnt);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Randomized scoreboard bench for mem_port_arbiter with a
//                behavioural memory and a transaction-level reference model.
//  Macro       : ARB_RR_EN (selects the tie-break rule of the model)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 3;

  logic              Clock  = 1'b0;
  logic              ResetN = 1'b0;
  logic              IfReq, DmReq, DmWe;
  logic [ADDR_W-1:0] IfAddr, DmAddr;
  logic [DATA_W-1:0] DmWData;
  logic              IfGnt, IfValid, DmGnt, DmValid;
  logic [DATA_W-1:0] IfRData, DmRData;
  logic              MemEn, MemWe, Stall;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData, MemRData;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfGnt(IfGnt), .IfValid(IfValid), .IfRData(IfRData),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWData(DmWData),
    .DmGnt(DmGnt), .DmValid(DmValid), .DmRData(DmRData),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .Stall(Stall)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit traffic_en = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Unwritten memory words hold a fixed address-derived pattern.
  function automatic logic [15:0] init_word(input logic [7:0] a);
    return {a, ~a} ^ 16'h3C5A;
  endfunction

  // ---------------- behavioural memory macro ----------------
  logic [15:0] dev_mem [0:255];
  bit          dev_wr  [0:255];
  logic [15:0] pipe    [0:MEM_LAT-1];

  always @(posedge Clock) begin
    if (MemEn && MemWe) begin
      dev_mem[MemAddr[7:0]] <= MemWData;
      dev_wr[MemAddr[7:0]]  <= 1'b1;
    end
    if (MemEn && !MemWe)
      pipe[0] <= dev_wr[MemAddr[7:0]] ? dev_mem[MemAddr[7:0]] : init_word(MemAddr[7:0]);
    else
      pipe[0] <= 16'($urandom);
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign MemRData = pipe[MEM_LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_dm;
    bit          is_store;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [int];
  int          free_at = 0;
  bit          last_dm = 1'b0;
  logic [15:0] exp_if_rdata = '0;
  logic [15:0] exp_dm_rdata = '0;

  // Grant-side model: predicts the winner, memory strobe and Stall each
  // cycle and queues the response the winner must later receive.
  always @(negedge Clock) begin
    bit   busy, e_if, e_dm, e_we;
    logic [15:0] e_addr, e_wd;
    int   a;
    exp_t e;
    if (!ResetN) begin
      sb.delete();
      free_at = 0;
      last_dm = 1'b0;
    end else begin
      busy = (cyc < free_at);
      e_if = 1'b0;
      e_dm = 1'b0;
      if (!busy && (IfReq || DmReq)) begin
        if (IfReq && DmReq) begin
`ifdef ARB_RR_EN
          e_dm = !last_dm;
`else
          e_dm = 1'b1;
`endif
        end else begin
          e_dm = DmReq;
        end
        e_if = !e_dm;
      end
      e_we   = e_dm && DmWe;
      e_addr = e_dm ? DmAddr : (e_if ? IfAddr : 16'h0);
      e_wd   = e_dm ? DmWData : 16'h0;
      check("if_gnt",    32'(IfGnt),    32'(e_if));
      check("dm_gnt",    32'(DmGnt),    32'(e_dm));
      check("mem_en",    32'(MemEn),    32'(e_if | e_dm));
      check("mem_we",    32'(MemWe),    32'(e_we));
      check("mem_addr",  32'(MemAddr),  32'(e_addr));
      check("mem_wdata", 32'(MemWData), 32'(e_wd));
      check("stall",     32'(Stall),    32'(busy | (IfReq & !e_if) | (DmReq & !e_dm)));
      if (e_if || e_dm) begin
        a          = int'(e_addr[7:0]);
        e.is_dm    = e_dm;
        e.is_store = e_we;
        e.due      = cyc + MEM_LAT + 1;
        if (e_we) begin
          ref_mem[a] = DmWData;
          e.data     = '0;
        end else begin
          e.data = ref_mem.exists(a) ? ref_mem[a] : init_word(e_addr[7:0]);
        end
        sb.push_back(e);
        free_at = cyc + MEM_LAT + 1;
        last_dm = e_dm;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a Valid pulse appears.
  always @(negedge Clock) begin
    exp_t e;
    if (!ResetN) begin
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL valid_timeout at cycle %0d: got none expected pulse at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (IfValid || DmValid) begin
        if (sb.size() == 0) begin
          check("valid_spurious", 32'({IfValid, DmValid}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("valid_cycle", 32'(cyc), 32'(e.due));
          check("valid_who", 32'({IfValid, DmValid}), e.is_dm ? 32'd1 : 32'd2);
          if (e.is_dm) begin
            if (!e.is_store) exp_dm_rdata = e.data;
            check("dm_rdata", 32'(DmRData), 32'(exp_dm_rdata));
          end else begin
            exp_if_rdata = e.data;
            check("if_rdata", 32'(IfRData), 32'(exp_if_rdata));
          end
        end
      end
    end
  end

  // ---------------- request drivers ----------------
  initial begin
    bit g;
    IfReq = 1'b0; IfAddr = '0;
    forever begin
      @(negedge Clock); g = IfGnt;
      @(posedge Clock); #1;
      if (IfReq && g) begin
        if (traffic_en && $urandom_range(0, 1) == 1) IfAddr = 16'($urandom);
        else IfReq = 1'b0;
      end else if (!IfReq && traffic_en && $urandom_range(0, 2) == 0) begin
        IfReq = 1'b1; IfAddr = 16'($urandom);
      end
    end
  end

  initial begin
    bit g;
    DmReq = 1'b0; DmWe = 1'b0; DmAddr = '0; DmWData = '0;
    forever begin
      @(negedge Clock); g = DmGnt;
      @(posedge Clock); #1;
      if ((DmReq && g && traffic_en && $urandom_range(0, 1) == 1) ||
          (!DmReq && traffic_en && $urandom_range(0, 2) == 0)) begin
        DmReq = 1'b1; DmWe = 1'($urandom_range(0, 1));
        DmAddr = 16'($urandom_range(0, 63)); DmWData = 16'($urandom);
      end else if (DmReq && g) begin
        DmReq = 1'b0;
      end
    end
  end

  // Stop new traffic and wait (bounded) for every access to complete.
  task automatic drain();
    traffic_en = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clock);
      if (!IfReq && !DmReq && sb.size() == 0) break;
    end
    check("drain", 32'({IfReq, DmReq, sb.size() != 0}), 32'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    bit got;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_if_valid", 32'(IfValid), 32'd0);
    check("rst_dm_valid", 32'(DmValid), 32'd0);
    check("rst_if_rdata", 32'(IfRData), 32'd0);
    check("rst_dm_rdata", 32'(DmRData), 32'd0);
    check("rst_stall",    32'(Stall),   32'd0);
    check("rst_mem_en",   32'(MemEn),   32'd0);
    @(posedge Clock); #1;
    ResetN = 1'b1;
    traffic_en = 1'b1;
    repeat (1500) @(posedge Clock);
    drain();

    // idle bus: per-cycle model checks cover MemEn/MemAddr/Stall/Valid
    repeat (20) @(posedge Clock);

    // reset in the cycle after a fetch grant
    @(posedge Clock); #1;
    IfReq = 1'b1; IfAddr = 16'h0010;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge Clock); got = IfGnt;
    end
    check("mid_rst_grant", 32'(got), 32'd1);
    @(posedge Clock); #1;
    ResetN = 1'b0;
    @(posedge Clock); #1;
    ResetN = 1'b1;
    IfReq = 1'b1; IfAddr = 16'h0020;
    @(negedge Clock);
    check("mid_rst_regrant",  32'(IfGnt),   32'd1);
    check("mid_rst_if_rdata", 32'(IfRData), 32'd0);
    check("mid_rst_if_valid", 32'(IfValid), 32'd0);
    drain();

    traffic_en = 1'b1;
    repeat (800) @(posedge Clock);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
